// File: rtl/coin_lane_controller.sv
// coin_lane_controller
//   Picks a lane for the next coin and enables that lane's coin sprite. It waits
//   for the coin to report in_position, then watches for pixel overlap between
//   the coin and the player during a collection window of frames. Every coin
//   ends in either a collection (score) or a miss (miss count). Runs on the
//   pixel clock. Frame timing comes from rising edges of i_v_sync.
//
// Ports
//   i_clk, i_rst_n   pixel clock, asynchronous active-low reset
//   i_v_sync         vertical sync; its rising edge is the frame tick
//   i_start          start/restart a game from IDLE or OVER (level)
//   i_enable         low forces IDLE and holds score/misses
//   i_in_position    per-lane coin in_position (bit0 left, bit1 centre, bit2 right)
//   i_coin_hit       per-lane coin opaque-pixel hit
//   i_player_hit     player opaque-pixel hit
//   o_coin_active    one-hot (or zero) lane enable to the coin sprites
//   o_score          accumulated score, saturating
//   o_misses         miss count, saturating at 3
//   o_collected      one-cycle pulse on a collection
//   o_missed         one-cycle pulse on a miss
//   o_game_over      high while in OVER
//   o_state          current FSM state, for debug
module coin_lane_controller #(
  parameter int          WINDOW_FRAMES   = 8,
  parameter int          COOLDOWN_FRAMES = 2,
  parameter int          TRAVEL_TIMEOUT  = 64,
  parameter int          COIN_VALUE      = 10,
  parameter int          MISS_LIMIT      = 3,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_v_sync,
  input  logic        i_start,
  input  logic        i_enable,
  input  logic [2:0]  i_in_position,
  input  logic [2:0]  i_coin_hit,
  input  logic        i_player_hit,
  output logic [2:0]  o_coin_active,
  output logic [15:0] o_score,
  output logic [1:0]  o_misses,
  output logic        o_collected,
  output logic        o_missed,
  output logic        o_game_over,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SPAWN    = 3'd1,
    S_TRAVEL   = 3'd2,
    S_WINDOW   = 3'd3,
    S_COLLECT  = 3'd4,
    S_MISS     = 3'd5,
    S_COOLDOWN = 3'd6,
    S_OVER     = 3'd7
  } state_t;

  localparam int MAX_WC     = (WINDOW_FRAMES > COOLDOWN_FRAMES) ? WINDOW_FRAMES : COOLDOWN_FRAMES;
  localparam int MAX_FRAMES = (MAX_WC > TRAVEL_TIMEOUT) ? MAX_WC : TRAVEL_TIMEOUT;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] sat_add(input logic [15:0] a);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(COIN_VALUE);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] a);
    return (a == 2'd3) ? 2'd3 : a + 2'd1;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  state_t             state_q, state_d;
  logic               v_sync_q;
  logic [15:0]        lfsr_q;
  logic [1:0]         lane_q, lane_d, lane_sel;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               flag_q, flag_d;
  logic [2:0]         active_q, active_d;
  logic [15:0]        score_q, score_d;
  logic [1:0]         misses_q, misses_d;
  logic               collected_q, collected_d;
  logic               missed_q, missed_d;
  logic               game_over_q, game_over_d;
  logic               tick, overlap_now;

  assign tick        = i_v_sync & ~v_sync_q;
  assign overlap_now = i_coin_hit[lane_q] & i_player_hit;
  assign cnt_inc     = cnt_q + 1'b1;
  // Lane 3 does not exist; fold it onto the centre lane.
  assign lane_sel    = (lfsr_q[1:0] == 2'd3) ? 2'd1 : lfsr_q[1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      v_sync_q    <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      lane_q      <= 2'd0;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      active_q    <= 3'b000;
      score_q     <= 16'h0000;
      misses_q    <= 2'd0;
      collected_q <= 1'b0;
      missed_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_sync_q    <= i_v_sync;
      lfsr_q      <= lfsr_next(lfsr_q);
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      active_q    <= active_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      collected_q <= collected_d;
      missed_q    <= missed_d;
      game_over_q <= game_over_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    flag_d      = flag_q;
    active_d    = 3'b000;
    score_d     = score_q;
    misses_d    = misses_q;
    collected_d = 1'b0;
    missed_d    = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (i_start) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        lane_d  = lane_sel;
        cnt_d   = '0;
        state_d = S_TRAVEL;
      end
      S_TRAVEL: begin
        if (i_in_position[lane_q]) begin
          state_d = S_WINDOW;
          flag_d  = 1'b0;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(TRAVEL_TIMEOUT)) state_d = S_MISS;
        end
      end
      S_WINDOW: begin
        if (overlap_now) flag_d = 1'b1;
        // A coin that dropped in_position has re-homed itself: that is a miss now.
        if (!i_in_position[lane_q]) begin
          state_d = S_MISS;
        end else if (tick) begin
          if (flag_q | overlap_now) begin
            state_d = S_COLLECT;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(WINDOW_FRAMES)) state_d = S_MISS;
          end
        end
      end
      S_COLLECT: begin
        cnt_d   = '0;
        state_d = S_COOLDOWN;
      end
      S_MISS: begin
        cnt_d   = '0;
        state_d = (int'(misses_q) >= MISS_LIMIT) ? S_OVER : S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(COOLDOWN_FRAMES)) state_d = S_SPAWN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!i_enable) state_d = S_IDLE;

    // Entry actions are keyed on the final next state so that dropping
    // i_enable cancels a collection or miss in the same cycle.
    if (state_d == S_COLLECT) begin
      collected_d = 1'b1;
      score_d     = sat_add(score_q);
    end
    if (state_d == S_MISS) begin
      missed_d = 1'b1;
      misses_d = sat_inc(misses_q);
    end
    if (state_d == S_SPAWN && (state_q == S_IDLE || state_q == S_OVER)) begin
      score_d  = 16'h0000;
      misses_d = 2'd0;
    end

    if (state_q == S_SPAWN && state_d == S_TRAVEL)
      active_d = 3'b001 << lane_sel;
    else if (state_d == S_TRAVEL || state_d == S_WINDOW)
      active_d = active_q;

    game_over_d = (state_d == S_OVER);
  end

  assign o_coin_active = active_q;
  assign o_score       = score_q;
  assign o_misses      = misses_q;
  assign o_collected   = collected_q;
  assign o_missed      = missed_q;
  assign o_game_over   = game_over_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_coin_lane_controller.sv
module tb_coin_lane_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_sync = 1'b0;
  logic        start = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  in_pos = 3'b000;
  logic [2:0]  coin_hit = 3'b000;
  logic        player = 1'b0;

  logic [2:0]  o_coin_active, s_coin_active;
  logic [15:0] o_score, s_score;
  logic [1:0]  o_misses, s_misses;
  logic        o_collected, s_collected;
  logic        o_missed, s_missed;
  logic        o_game_over, s_game_over;
  logic [2:0]  o_state, s_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  coin_lane_controller dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_v_sync(v_sync), .i_start(start),
    .i_enable(enable), .i_in_position(in_pos), .i_coin_hit(coin_hit),
    .i_player_hit(player), .o_coin_active(o_coin_active), .o_score(o_score),
    .o_misses(o_misses), .o_collected(o_collected), .o_missed(o_missed),
    .o_game_over(o_game_over), .o_state(o_state)
  );

  // Second instance with a large coin value, driven identically, to reach
  // score saturation in a handful of coins.
  coin_lane_controller #(.COIN_VALUE(16'h6000)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_v_sync(v_sync), .i_start(start),
    .i_enable(enable), .i_in_position(in_pos), .i_coin_hit(coin_hit),
    .i_player_hit(player), .o_coin_active(s_coin_active), .o_score(s_score),
    .o_misses(s_misses), .o_collected(s_collected), .o_missed(s_missed),
    .o_game_over(s_game_over), .o_state(s_state)
  );

  // Reference lane generator: Galois LFSR x^16+x^14+x^13+x^11+1, stepping every clock.
  logic [15:0] m_lfsr;
  function automatic logic [15:0] model_step(input logic [15:0] v);
    logic [15:0] taps;
    taps = (16'd1 << 15) | (16'd1 << 13) | (16'd1 << 12) | (16'd1 << 10);
    return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= model_step(m_lfsr);
  end

  function automatic logic [1:0] lane_of(input logic [15:0] v);
    return (v[1:0] == 2'd3) ? 2'd1 : v[1:0];
  endfunction
  function automatic logic [2:0] oh(input logic [1:0] l);
    return 3'b001 << l;
  endfunction

  typedef struct {
    bit st, en, vs, ip, hl, ho, ph;
    logic [2:0]  e_state;
    bit          e_act, e_col, e_mis;
    logic [15:0] e_score;
    logic [1:0]  e_misses;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit st, bit en, bit vs, bit ip, bit hl, bit ho, bit ph,
                              logic [2:0] es, bit ea, bit ec, bit em,
                              logic [15:0] esc, logic [1:0] emi);
    vec_t r;
    r.st = st; r.en = en; r.vs = vs; r.ip = ip; r.hl = hl; r.ho = ho; r.ph = ph;
    r.e_state = es; r.e_act = ea; r.e_col = ec; r.e_mis = em;
    r.e_score = esc; r.e_misses = emi;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_tick();
    v_sync = 1'b1; cycle();
    v_sync = 1'b0; cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " state"}, o_state, 0);
    chk({tag, " active"}, o_coin_active, 0);
    chk({tag, " score"}, o_score, 0);
    chk({tag, " misses"}, o_misses, 0);
    chk({tag, " collected"}, o_collected, 0);
    chk({tag, " missed"}, o_missed, 0);
    chk({tag, " game_over"}, o_game_over, 0);
  endtask

  // Keep overlap and in_position asserted on every lane and let frames run
  // until a coin is collected, bounded by a cycle budget.
  task automatic collect_fast(input logic [15:0] exp_score, input logic [15:0] exp_sat);
    bit seen;
    seen = 1'b0;
    in_pos = 3'b111; coin_hit = 3'b111; player = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      v_sync = ~v_sync;
      cycle();
      if (o_collected) seen = 1'b1;
    end
    chk("fast collect seen", seen, 1);
    chk("fast collect state", o_state, 4);
    chk("fast collect score", o_score, exp_score);
    chk("fast collect sat score", s_score, exp_sat);
  endtask

  logic [1:0] exp_lane, first_lane;
  logic [2:0] exp_act;

  initial begin
    exp_lane = 2'd0;
    first_lane = 2'd0;

    // Collect, then a coin that expires with only wrong-lane overlap.
    tbl.push_back(mk(1,1,0,0,0,0,0, 3'd1,0,0,0, 16'd0,2'd0));
    tbl.push_back(mk(0,1,0,0,0,0,0, 3'd2,1,0,0, 16'd0,2'd0));
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk(0,1,1,0,0,0,0, 3'd2,1,0,0, 16'd0,2'd0));
      tbl.push_back(mk(0,1,0,0,0,0,0, 3'd2,1,0,0, 16'd0,2'd0));
    end
    tbl.push_back(mk(0,1,0,1,0,0,0, 3'd3,1,0,0, 16'd0,2'd0));
    tbl.push_back(mk(0,1,0,1,1,0,1, 3'd3,1,0,0, 16'd0,2'd0));
    tbl.push_back(mk(0,1,1,1,0,0,0, 3'd4,0,1,0, 16'd10,2'd0));
    tbl.push_back(mk(0,1,0,0,0,0,0, 3'd6,0,0,0, 16'd10,2'd0));
    tbl.push_back(mk(0,1,1,0,0,0,0, 3'd6,0,0,0, 16'd10,2'd0));
    tbl.push_back(mk(0,1,0,0,0,0,0, 3'd6,0,0,0, 16'd10,2'd0));
    tbl.push_back(mk(0,1,1,0,0,0,0, 3'd1,0,0,0, 16'd10,2'd0));
    tbl.push_back(mk(0,1,0,0,0,0,0, 3'd2,1,0,0, 16'd10,2'd0));
    tbl.push_back(mk(0,1,0,1,0,0,0, 3'd3,1,0,0, 16'd10,2'd0));
    tbl.push_back(mk(0,1,0,1,0,1,1, 3'd3,1,0,0, 16'd10,2'd0));
    for (int k = 0; k < 7; k++) begin
      tbl.push_back(mk(0,1,1,1,0,1,1, 3'd3,1,0,0, 16'd10,2'd0));
      tbl.push_back(mk(0,1,0,1,0,0,0, 3'd3,1,0,0, 16'd10,2'd0));
    end
    tbl.push_back(mk(0,1,1,1,0,0,0, 3'd5,0,0,1, 16'd10,2'd1));
    tbl.push_back(mk(0,1,0,0,0,0,0, 3'd6,0,0,0, 16'd10,2'd1));

    // Reset state.
    repeat (3) cycle();
    chk_all_zero("reset");
    rst_n = 1'b1;
    enable = 1'b1;
    cycle();
    cycle();
    chk("idle state", o_state, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      start  = tbl[i].st;
      enable = tbl[i].en;
      v_sync = tbl[i].vs;
      in_pos = tbl[i].ip ? oh(exp_lane) : 3'b000;
      coin_hit = (tbl[i].hl ? oh(exp_lane) : 3'b000) |
                 (tbl[i].ho ? oh((exp_lane == 2'd2) ? 2'd0 : exp_lane + 2'd1) : 3'b000);
      player = tbl[i].ph;
      cycle();
      exp_act = tbl[i].e_act ? oh(exp_lane) : 3'b000;
      chk($sformatf("row%0d state", i), o_state, tbl[i].e_state);
      chk($sformatf("row%0d active", i), o_coin_active, exp_act);
      chk($sformatf("row%0d collected", i), o_collected, tbl[i].e_col);
      chk($sformatf("row%0d missed", i), o_missed, tbl[i].e_mis);
      chk($sformatf("row%0d score", i), o_score, tbl[i].e_score);
      chk($sformatf("row%0d misses", i), o_misses, tbl[i].e_misses);
      if (tbl[i].e_state == 3'd1) begin
        exp_lane = lane_of(m_lfsr);
        if (i == 0) first_lane = exp_lane;
      end
    end
    chk("table sat score", s_score, 16'h6000);
    start = 1'b0; in_pos = 3'b000; coin_hit = 3'b000; player = 1'b0; v_sync = 1'b0;

    // Travel timeout: in_position never rises.
    frame_tick();
    frame_tick();
    chk("timeout travel entered", o_state, 2);
    repeat (63) frame_tick();
    chk("timeout still travel", o_state, 2);
    v_sync = 1'b1; cycle();
    chk("timeout state", o_state, 5);
    chk("timeout missed", o_missed, 1);
    chk("timeout misses", o_misses, 2);
    chk("timeout active", o_coin_active, 0);
    v_sync = 1'b0; cycle();
    chk("timeout cooldown", o_state, 6);
    chk("timeout pulse width", o_missed, 0);

    // Re-home during WINDOW is an immediate miss; the third miss ends the game.
    frame_tick();
    frame_tick();
    chk("rehome travel", o_state, 2);
    in_pos = 3'b111; cycle();
    chk("rehome window", o_state, 3);
    cycle();
    in_pos = 3'b000; cycle();
    chk("rehome state", o_state, 5);
    chk("rehome missed", o_missed, 1);
    chk("rehome misses", o_misses, 3);
    cycle();
    chk("over state", o_state, 7);
    chk("over game_over", o_game_over, 1);
    chk("over active", o_coin_active, 0);
    chk("over score held", o_score, 10);
    chk("over missed pulse", o_missed, 0);
    start = 1'b1; cycle();
    start = 1'b0;
    chk("restart state", o_state, 1);
    chk("restart score", o_score, 0);
    chk("restart misses", o_misses, 0);
    chk("restart game_over", o_game_over, 0);

    // Score accumulation and saturation.
    collect_fast(16'd10, 16'h6000);
    collect_fast(16'd20, 16'hC000);
    collect_fast(16'd30, 16'hFFFF);
    collect_fast(16'd40, 16'hFFFF);

    // Asynchronous reset in the middle of a WINDOW.
    coin_hit = 3'b000; player = 1'b0; v_sync = 1'b0;
    cycle();
    frame_tick();
    frame_tick();
    cycle();
    chk("prereset window", o_state, 3);
    chk("prereset score", o_score, 40);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    in_pos = 3'b000;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    start = 1'b1; cycle();
    start = 1'b0;
    chk("repeat spawn", o_state, 1);
    exp_lane = lane_of(m_lfsr);
    cycle();
    chk("repeat first lane", o_coin_active, oh(first_lane));
    chk("repeat model lane", o_coin_active, oh(exp_lane));

    // Enable dropped on the tick that would collect.
    collect_fast(16'd10, 16'h6000);
    coin_hit = 3'b000; player = 1'b0; v_sync = 1'b0;
    cycle();
    frame_tick();
    frame_tick();
    cycle();
    chk("drop window", o_state, 3);
    coin_hit = 3'b111; player = 1'b1; cycle();
    coin_hit = 3'b000; player = 1'b0;
    v_sync = 1'b1; enable = 1'b0; cycle();
    chk("drop state", o_state, 0);
    chk("drop collected", o_collected, 0);
    chk("drop missed", o_missed, 0);
    chk("drop score", o_score, 10);
    chk("drop active", o_coin_active, 0);
    v_sync = 1'b0; enable = 1'b1; cycle();
    chk("drop idle hold", o_state, 0);
    chk("drop no late pulse", o_collected, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1);
  end

endmodule
